mmio_port_arbiter: RTL

//  Shares the single-port 64x32 memory-mapped register block between two requesters:
//  - port C: CPU load/store
//  - port I: IO bridge (PS2 scancode writes, VGA word fetches)

---
 rtl/mmio_port_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mmio_port_arbiter.sv
// Arbitrates the single-port memory-mapped register block between the CPU and the IO bridge.
// CPU has fixed priority, an aging counter forces IO through, and lock sequences give atomic RMW.
module mmio_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int PS2_ADDR = 62
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic              c_lock,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_err,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_lock,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] mem_dir,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOCK_C,
    LOCK_I
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_waitCnt;
  logic              w_cGnt;
  logic              w_iGnt;
  logic              w_cPs2Write;
  logic              r_cRvalid;
  logic              r_iRvalid;
  logic              r_cErr;
  logic [DATA_W-1:0] r_cRdata;
  logic [DATA_W-1:0] r_iRdata;

  // Grants depend only on requests and registered state, never on each other's gnt.
  always_comb begin
    w_cGnt      = 1'b0;
    w_iGnt      = 1'b0;
    w_nextState = r_state;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (c_req && i_req) begin
            if (r_waitCnt == CNT_W'(MAX_WAIT)) w_iGnt = 1'b1;
            else                               w_cGnt = 1'b1;
          end else if (c_req) begin
            w_cGnt = 1'b1;
          end else if (i_req) begin
            w_iGnt = 1'b1;
          end
        end
        LOCK_C:  w_cGnt = c_req;
        LOCK_I:  w_iGnt = i_req;
        default: ;
      endcase
    end
    if (w_cGnt)      w_nextState = c_lock ? LOCK_C : IDLE;
    else if (w_iGnt) w_nextState = i_lock ? LOCK_I : IDLE;
  end

  assign w_cPs2Write = c_we && (c_addr == ADDR_W'(PS2_ADDR));

  assign c_gnt     = w_cGnt;
  assign i_gnt     = w_iGnt;
  assign mem_we    = (w_cGnt && c_we && !w_cPs2Write) || (w_iGnt && i_we);
  assign mem_dir   = w_cGnt ? c_addr  : (w_iGnt ? i_addr  : '0);
  assign mem_wdata = w_cGnt ? c_wdata : (w_iGnt ? i_wdata : '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_iGnt)
        r_waitCnt <= '0;
      else if (i_req && (r_waitCnt != CNT_W'(MAX_WAIT)))
        r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  // Read data is held after the one-cycle rvalid pulse until the next read of that port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cRvalid <= 1'b0;
      r_iRvalid <= 1'b0;
      r_cErr    <= 1'b0;
      r_cRdata  <= '0;
      r_iRdata  <= '0;
    end else begin
      r_cRvalid <= w_cGnt && !c_we;
      r_iRvalid <= w_iGnt && !i_we;
      r_cErr    <= w_cGnt && w_cPs2Write;
      if (w_cGnt && !c_we) r_cRdata <= mem_rdata;
      if (w_iGnt && !i_we) r_iRdata <= mem_rdata;
    end
  end

  assign c_rvalid = r_cRvalid;
  assign i_rvalid = r_iRvalid;
  assign c_err    = r_cErr;
  assign c_rdata  = r_cRdata;
  assign i_rdata  = r_iRdata;

endmodule
